// File: rtl/ama_riscv_fetch_pkg.sv
// Shared fetch-stage encodings: next-PC selects, the NOP bubble and the default reset vector.
// Imported by the PC generator, the fetch top and the decoder.
package ama_riscv_fetch_pkg;

   typedef enum logic [1:0] {
      PC_SEL_INC4       = 2'd0,
      PC_SEL_ALU        = 2'd1,
      PC_SEL_BP         = 2'd2,  // reserved, behaves as INC4
      PC_SEL_START_ADDR = 2'd3
   } pc_sel_t;

   localparam logic [31:0] NOP                  = 32'h0000_0013;  // addi x0, x0, 0
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/ama_riscv_pc_gen.sv
// Program counter: next-PC mux, PC register and the IMEM word address.
// The address looks ahead to pc_next so the synchronous IMEM read lands aligned with pc.
module ama_riscv_pc_gen
   import ama_riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter int          IMEM_AW      = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         pc_sel,
   input  logic               pc_we,
   input  logic [29:0]        alu_tgt,
   output logic [31:0]        pc,
   output logic [IMEM_AW-1:0] imem_addr
);

   pc_sel_t     sel;
   logic [31:0] pc_next;

   assign sel = pc_sel_t'(pc_sel);

   // NOTE: every path assigns pc_next, so the default arm keeps this mux latch-free.
   always_comb begin
      pc_next = pc + 32'd4;
      case (sel)
         PC_SEL_ALU:        pc_next = {alu_tgt, 2'b00};
         PC_SEL_START_ADDR: pc_next = RESET_VECTOR;
         default:           pc_next = pc + 32'd4;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst)        pc <= RESET_VECTOR;
      else if (pc_we) pc <= pc_next;
   end

   assign imem_addr = pc_we ? pc_next[IMEM_AW+1:2] : pc[IMEM_AW+1:2];

endmodule

// File: rtl/ama_riscv_fetch.sv
// Instruction fetch stage: drives IMEM, inserts NOP bubbles on reset/stall/clear,
// flags the first misaligned control-flow target and counts delivered instructions.
module ama_riscv_fetch
   import ama_riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter int          IMEM_AW      = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         pc_sel,
   input  logic               pc_we,
   input  logic               stall_if,
   input  logic               clear_if,
   input  logic [31:0]        alu_out,
   input  logic [31:0]        imem_rdata,
   output logic               imem_en,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        inst_id,
   output logic [31:0]        pc_id,
   output logic               inst_valid_id,
   output logic               misalign_err,
   output logic [31:0]        misalign_addr,
   output logic [31:0]        fetch_cnt
);

   logic [31:0] pc;
   logic        bubble_q;
   logic [31:0] fetch_cnt_q;
   logic        misalign_hit;

   ama_riscv_pc_gen #(
      .RESET_VECTOR (RESET_VECTOR),
      .IMEM_AW      (IMEM_AW)
   ) u_pc_gen (
      .clk       (clk),
      .rst       (rst),
      .pc_sel    (pc_sel),
      .pc_we     (pc_we),
      .alu_tgt   (alu_out[31:2]),
      .pc        (pc),
      .imem_addr (imem_addr)
   );

   assign imem_en = !rst;

   // The slot after reset, stall or flush carries a NOP instead of the IMEM word.
   always_ff @(posedge clk) begin
      if (rst) bubble_q <= 1'b1;
      else     bubble_q <= stall_if | clear_if;
   end

   assign inst_id       = bubble_q ? NOP : imem_rdata;
   assign inst_valid_id = !bubble_q;
   assign pc_id         = pc;

   // Only a committed jump/branch is checked; fetch itself proceeds at the aligned target.
   assign misalign_hit = pc_we && (pc_sel == PC_SEL_ALU) && is_misaligned(alu_out[1:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_err  <= 1'b0;
         misalign_addr <= 32'd0;
      end else if (misalign_hit && !misalign_err) begin
         misalign_err  <= 1'b1;
         misalign_addr <= alu_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                fetch_cnt_q <= 32'd0;
      else if (inst_valid_id) fetch_cnt_q <= fetch_cnt_q + 32'd1;
   end

   assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Directed bench for ama_riscv_fetch: a vector table of per-cycle controls and expected
// ID outputs, plus hand-written reset and counter-wrap sequences.
module tb_ama_riscv_fetch;

   localparam int          AW  = 14;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] I0  = 32'h0050_0093;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    pc_sel;
   logic          pc_we, stall_if, clear_if;
   logic [31:0]   alu_out;
   logic [31:0]   imem_rdata;
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [31:0]   inst_id, pc_id, misalign_addr, fetch_cnt;
   logic          inst_valid_id, misalign_err;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] imem [0:255];

   always #5 clk = ~clk;

   // Synchronous IMEM model: word w holds 32'h1000_0000 + w, except word 0.
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= imem[imem_addr[7:0]];
   end

   ama_riscv_fetch #(
      .RESET_VECTOR (32'h0000_0000),
      .IMEM_AW      (AW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_sel        (pc_sel),
      .pc_we         (pc_we),
      .stall_if      (stall_if),
      .clear_if      (clear_if),
      .alu_out       (alu_out),
      .imem_rdata    (imem_rdata),
      .imem_en       (imem_en),
      .imem_addr     (imem_addr),
      .inst_id       (inst_id),
      .pc_id         (pc_id),
      .inst_valid_id (inst_valid_id),
      .misalign_err  (misalign_err),
      .misalign_addr (misalign_addr),
      .fetch_cnt     (fetch_cnt)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  sel;
      logic        we;
      logic        stall;
      logic        clear;
      logic [31:0] alu;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic        e_valid;
      logic        e_err;
      logic [31:0] e_maddr;
      logic [31:0] e_cnt;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   function automatic logic [31:0] m(input int w);
      return 32'h1000_0000 + w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [1:0] s, input logic w,
                        input logic st, input logic cl, input logic [31:0] a);
      rst      = r;
      pc_sel   = s;
      pc_we    = w;
      stall_if = st;
      clear_if = cl;
      alu_out  = a;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = m(i);
      imem[0] = I0;

      //           rst sel we st cl alu           inst         pc           v  err maddr        cnt
      vecs[0]  = '{0, 2'd3, 1, 0, 0, 32'h0,     I0,          32'h00,      1, 0, 32'h0,  32'd0};
      vecs[1]  = '{0, 2'd0, 1, 0, 0, 32'h0,     m(1),        32'h04,      1, 0, 32'h0,  32'd1};
      vecs[2]  = '{0, 2'd0, 1, 0, 0, 32'h0,     m(2),        32'h08,      1, 0, 32'h0,  32'd2};
      vecs[3]  = '{0, 2'd0, 1, 0, 0, 32'h0,     m(3),        32'h0C,      1, 0, 32'h0,  32'd3};
      vecs[4]  = '{0, 2'd0, 1, 0, 0, 32'h0,     m(4),        32'h10,      1, 0, 32'h0,  32'd4};
      vecs[5]  = '{0, 2'd0, 1, 0, 0, 32'h0,     m(5),        32'h14,      1, 0, 32'h0,  32'd5};
      vecs[6]  = '{0, 2'd0, 1, 0, 0, 32'h0,     m(6),        32'h18,      1, 0, 32'h0,  32'd6};
      vecs[7]  = '{0, 2'd0, 1, 0, 0, 32'h0,     m(7),        32'h1C,      1, 0, 32'h0,  32'd7};
      vecs[8]  = '{0, 2'd1, 1, 0, 0, 32'h10,    m(4),        32'h10,      1, 0, 32'h0,  32'd8};
      // branch in ID: stall, then resolve to 0x40
      vecs[9]  = '{0, 2'd0, 0, 1, 0, 32'h0,     NOP,         32'h10,      0, 0, 32'h0,  32'd9};
      vecs[10] = '{0, 2'd1, 1, 0, 0, 32'h40,    m(16),       32'h40,      1, 0, 32'h0,  32'd9};
      vecs[11] = '{0, 2'd0, 0, 1, 0, 32'h0,     NOP,         32'h40,      0, 0, 32'h0,  32'd10};
      vecs[12] = '{0, 2'd0, 0, 1, 0, 32'h0,     NOP,         32'h40,      0, 0, 32'h0,  32'd10};
      vecs[13] = '{0, 2'd0, 0, 0, 0, 32'h0,     m(16),       32'h40,      1, 0, 32'h0,  32'd10};
      // misaligned targets: only the first is recorded
      vecs[14] = '{0, 2'd1, 1, 0, 0, 32'h42,    m(16),       32'h40,      1, 1, 32'h42, 32'd11};
      vecs[15] = '{0, 2'd1, 1, 0, 0, 32'h86,    m(33),       32'h84,      1, 1, 32'h42, 32'd12};
      vecs[16] = '{0, 2'd1, 0, 0, 0, 32'h0A,    m(33),       32'h84,      1, 1, 32'h42, 32'd13};
      // clear + stall together: one bubble
      vecs[17] = '{0, 2'd0, 1, 1, 1, 32'h0,     NOP,         32'h88,      0, 1, 32'h42, 32'd14};
      vecs[18] = '{0, 2'd0, 1, 0, 0, 32'h0,     m(35),       32'h8C,      1, 1, 32'h42, 32'd14};
      vecs[19] = '{0, 2'd2, 1, 0, 0, 32'h0,     m(36),       32'h90,      1, 1, 32'h42, 32'd15};
      vecs[20] = '{0, 2'd1, 1, 0, 1, 32'h100,   NOP,         32'h100,     0, 1, 32'h42, 32'd16};
      vecs[21] = '{0, 2'd0, 1, 0, 0, 32'h0,     m(65),       32'h104,     1, 1, 32'h42, 32'd16};
      // reset mid-branch, then restart
      vecs[22] = '{1, 2'd1, 1, 0, 0, 32'h200,   NOP,         32'h00,      0, 0, 32'h0,  32'd0};
      vecs[23] = '{0, 2'd3, 1, 0, 0, 32'h0,     I0,          32'h00,      1, 0, 32'h0,  32'd0};
      // ALU select without pc_we: no PC change, no misalign check
      vecs[24] = '{0, 2'd1, 0, 0, 0, 32'h13,    I0,          32'h00,      1, 0, 32'h0,  32'd1};

      // Reset held for three cycles
      drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (3) step();
      check("reset imem_en",       {31'd0, imem_en},       32'd0);
      check("reset inst_id",       inst_id,                NOP);
      check("reset inst_valid",    {31'd0, inst_valid_id}, 32'd0);
      check("reset pc_id",         pc_id,                  32'h0);
      check("reset misalign_err",  {31'd0, misalign_err},  32'd0);
      check("reset misalign_addr", misalign_addr,          32'h0);
      check("reset fetch_cnt",     fetch_cnt,              32'd0);

      // First post-reset cycle, before its edge: still a bubble
      drive(1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      check("post-reset imem_en",    {31'd0, imem_en},       32'd1);
      check("post-reset inst_id",    inst_id,                NOP);
      check("post-reset inst_valid", {31'd0, inst_valid_id}, 32'd0);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].sel, vecs[i].we, vecs[i].stall, vecs[i].clear, vecs[i].alu);
         step();
         check($sformatf("v%0d inst_id", i),       inst_id,                vecs[i].e_inst);
         check($sformatf("v%0d pc_id", i),         pc_id,                  vecs[i].e_pc);
         check($sformatf("v%0d inst_valid", i),    {31'd0, inst_valid_id}, {31'd0, vecs[i].e_valid});
         check($sformatf("v%0d misalign_err", i),  {31'd0, misalign_err},  {31'd0, vecs[i].e_err});
         check($sformatf("v%0d misalign_addr", i), misalign_addr,          vecs[i].e_maddr);
         check($sformatf("v%0d fetch_cnt", i),     fetch_cnt,              vecs[i].e_cnt);
      end

      // Counter wrap: preload all-ones while a valid instruction sits in ID
      force dut.fetch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_cnt_q;
      check("wrap preload", fetch_cnt, 32'hFFFF_FFFF);
      drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("wrap fetch_cnt", fetch_cnt,    32'd0);
      check("wrap pc_id",     pc_id,        32'h4);
      check("wrap inst_id",   inst_id,      m(1));
      step();
      check("post-wrap fetch_cnt", fetch_cnt, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
